// File: rtl/cdb_wb_sched_if.sv
// Issue/grant bundle between the issue stage and the writeback-port scheduler.
// Requests and flush come from issue; grants, owner select and status come back.
interface cdb_wb_sched_if #(
  parameter int MULT_LAT_P = 2
);
  localparam int CW = $clog2(MULT_LAT_P + 1);

  logic          alu_req_i;
  logic          mult_req_i;
  logic          mispredict_i;
  logic          alu_gnt_o;
  logic          mult_gnt_o;
  logic [1:0]    cdb_sel_o;
  logic [CW-1:0] mult_inflight_o;
  logic          alu_starved_o;

  modport master (
    output alu_req_i, mult_req_i, mispredict_i,
    input  alu_gnt_o, mult_gnt_o, cdb_sel_o, mult_inflight_o, alu_starved_o
  );

  modport slave (
    input  alu_req_i, mult_req_i, mispredict_i,
    output alu_gnt_o, mult_gnt_o, cdb_sel_o, mult_inflight_o, alu_starved_o
  );
endinterface

// File: rtl/cdb_wb_sched.sv
// Reserves the single writeback port at issue time: grants are same-cycle, ALU lands t+1, MULT t+MULT_LAT_P.
// A denied request simply stays pending; repeated ALU denials throttle multiplier grants.
module cdb_wb_sched #(
  parameter int MULT_LAT_P = 2,
  parameter int STARVE_P   = 4
) (
  input logic           clk_i,
  input logic           reset_i,
  cdb_wb_sched_if.slave bus
);
  localparam int CW = $clog2(MULT_LAT_P + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_ALU  = 2'b01,
    OWN_MULT = 2'b10
  } own_t;

  // Slot MULT_LAT_P is never occupied, so only slots 0..MULT_LAT_P-1 are stored.
  own_t          own_r [MULT_LAT_P];
  own_t          own_n [MULT_LAT_P];
  logic [3:0]    starve_cnt_r;
  logic          starve_r;
  logic          alu_gnt;
  logic          mult_gnt;
  logic [CW-1:0] inflight;

  assign mult_gnt = bus.mult_req_i & ~starve_r & ~bus.mispredict_i & ~reset_i;
  assign alu_gnt  = bus.alu_req_i & (own_r[1] == OWN_NONE) & ~bus.mispredict_i & ~reset_i;

  always_comb begin
    for (int k = 0; k < MULT_LAT_P - 1; k++) begin
      own_n[k] = own_r[k+1];
    end
    own_n[MULT_LAT_P-1] = OWN_NONE;
    // A flush kills every queued multiply; an ALU entry is already past the point of no return.
    for (int k = 0; k < MULT_LAT_P; k++) begin
      if (bus.mispredict_i && own_n[k] == OWN_MULT) begin
        own_n[k] = OWN_NONE;
      end
    end
    if (mult_gnt) begin
      own_n[MULT_LAT_P-1] = OWN_MULT;
    end
    if (alu_gnt) begin
      own_n[0] = OWN_ALU;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 1; k < MULT_LAT_P; k++) begin
      if (own_r[k] == OWN_MULT) begin
        inflight = inflight + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < MULT_LAT_P; k++) begin
        own_r[k] <= OWN_NONE;
      end
      starve_cnt_r <= 4'd0;
      starve_r     <= 1'b0;
    end else begin
      own_r <= own_n;
      if (alu_gnt || !bus.alu_req_i || bus.mispredict_i) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != 4'hF) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
      if (alu_gnt) begin
        starve_r <= 1'b0;
      end else if (starve_cnt_r >= 4'(STARVE_P)) begin
        starve_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (own_r[0] != 2'b11);
      assert (!(alu_gnt && own_r[1] != OWN_NONE));
    end
  end

  assign bus.alu_gnt_o       = alu_gnt;
  assign bus.mult_gnt_o      = mult_gnt;
  assign bus.cdb_sel_o       = own_r[0];
  assign bus.mult_inflight_o = inflight;
  assign bus.alu_starved_o   = starve_r;
endmodule

// File: tb/tb_cdb_wb_sched.sv
// Directed checks of cdb_wb_sched at MULT_LAT_P=2 and MULT_LAT_P=4, STARVE_P=4.
module tb_cdb_wb_sched;
  logic clk;
  logic rst2;
  logic rst4;
  int   nvec;
  int   nerr;

  cdb_wb_sched_if #(.MULT_LAT_P(2)) b2 ();
  cdb_wb_sched_if #(.MULT_LAT_P(4)) b4 ();

  cdb_wb_sched #(.MULT_LAT_P(2), .STARVE_P(4)) dut2 (
    .clk_i   (clk),
    .reset_i (rst2),
    .bus     (b2.slave)
  );

  cdb_wb_sched #(.MULT_LAT_P(4), .STARVE_P(4)) dut4 (
    .clk_i   (clk),
    .reset_i (rst4),
    .bus     (b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge; checks follow 1ns later.
  task automatic cyc2(input logic a, input logic m, input logic p, input logic r);
    @(negedge clk);
    b2.alu_req_i    = a;
    b2.mult_req_i   = m;
    b2.mispredict_i = p;
    rst2            = r;
    #1;
  endtask

  task automatic cyc4(input logic a, input logic m, input logic p, input logic r);
    @(negedge clk);
    b4.alu_req_i    = a;
    b4.mult_req_i   = m;
    b4.mispredict_i = p;
    rst4            = r;
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst2 = 1'b1;
    rst4 = 1'b1;
    b2.alu_req_i = 1'b0; b2.mult_req_i = 1'b0; b2.mispredict_i = 1'b0;
    b4.alu_req_i = 1'b0; b4.mult_req_i = 1'b0; b4.mispredict_i = 1'b0;

    // Reset, then idle
    cyc2(0, 0, 0, 1);
    chk("rst0_alu_gnt", b2.alu_gnt_o, 0);
    chk("rst0_mult_gnt", b2.mult_gnt_o, 0);
    cyc2(1, 1, 0, 1);
    chk("rst1_alu_gnt", b2.alu_gnt_o, 0);
    chk("rst1_mult_gnt", b2.mult_gnt_o, 0);
    chk("rst1_sel", b2.cdb_sel_o, 0);
    chk("rst1_inflight", b2.mult_inflight_o, 0);
    chk("rst1_starved", b2.alu_starved_o, 0);
    chk("rst1_sel4", b4.cdb_sel_o, 0);
    chk("rst1_inflight4", b4.mult_inflight_o, 0);
    cyc2(0, 0, 0, 0);
    chk("idle_sel", b2.cdb_sel_o, 0);
    chk("idle_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 0);

    // Isolated multiply then isolated ALU op
    cyc2(0, 1, 0, 0);
    chk("iso_mult_gnt", b2.mult_gnt_o, 1);
    chk("iso_mult_alu_gnt", b2.alu_gnt_o, 0);
    cyc2(0, 0, 0, 0);
    chk("iso_t1_sel", b2.cdb_sel_o, 0);
    chk("iso_t1_inflight", b2.mult_inflight_o, 1);
    cyc2(0, 0, 0, 0);
    chk("iso_t2_sel", b2.cdb_sel_o, 2);
    chk("iso_t2_inflight", b2.mult_inflight_o, 0);
    cyc2(0, 0, 0, 0);
    chk("iso_t3_sel", b2.cdb_sel_o, 0);
    cyc2(0, 0, 0, 0);
    cyc2(1, 0, 0, 0);
    chk("iso_t5_alu_gnt", b2.alu_gnt_o, 1);
    chk("iso_t5_mult_gnt", b2.mult_gnt_o, 0);
    cyc2(0, 0, 0, 0);
    chk("iso_t6_sel", b2.cdb_sel_o, 1);
    cyc2(0, 0, 0, 0);
    chk("iso_t7_sel", b2.cdb_sel_o, 0);

    // ALU blocked by a multiply landing next cycle, then retried
    cyc2(0, 1, 0, 0);
    chk("col_t0_mult_gnt", b2.mult_gnt_o, 1);
    cyc2(1, 0, 0, 0);
    chk("col_t1_alu_gnt", b2.alu_gnt_o, 0);
    cyc2(1, 0, 0, 0);
    chk("col_t2_alu_gnt", b2.alu_gnt_o, 1);
    chk("col_t2_sel", b2.cdb_sel_o, 2);
    cyc2(0, 0, 0, 0);
    chk("col_t3_sel", b2.cdb_sel_o, 1);

    // Same-cycle ALU and MULT grants
    cyc2(1, 1, 0, 0);
    chk("both_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 2'b11);
    cyc2(0, 0, 0, 0);
    chk("both_t1_sel", b2.cdb_sel_o, 1);
    chk("both_t1_inflight", b2.mult_inflight_o, 1);
    cyc2(0, 0, 0, 0);
    chk("both_t2_sel", b2.cdb_sel_o, 2);
    cyc2(0, 0, 0, 0);
    chk("both_t3_sel", b2.cdb_sel_o, 0);

    // Starvation: both requests held high
    cyc2(1, 1, 0, 0);
    chk("stv_u0_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 2'b11);
    cyc2(1, 1, 0, 0);
    chk("stv_u1_alu_gnt", b2.alu_gnt_o, 0);
    cyc2(1, 1, 0, 0);
    cyc2(1, 1, 0, 0);
    cyc2(1, 1, 0, 0);
    chk("stv_u4_alu_gnt", b2.alu_gnt_o, 0);
    chk("stv_u4_starved", b2.alu_starved_o, 0);
    cyc2(1, 1, 0, 0);
    chk("stv_u5_starved", b2.alu_starved_o, 0);
    chk("stv_u5_mult_gnt", b2.mult_gnt_o, 1);
    cyc2(1, 1, 0, 0);
    chk("stv_u6_starved", b2.alu_starved_o, 1);
    chk("stv_u6_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 2'b00);
    cyc2(1, 1, 0, 0);
    chk("stv_u7_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 2'b10);
    chk("stv_u7_starved", b2.alu_starved_o, 1);
    chk("stv_u7_sel", b2.cdb_sel_o, 2);
    cyc2(1, 1, 0, 0);
    chk("stv_u8_starved", b2.alu_starved_o, 0);
    chk("stv_u8_mult_gnt", b2.mult_gnt_o, 1);
    chk("stv_u8_sel", b2.cdb_sel_o, 1);
    cyc2(0, 0, 0, 0);
    cyc2(0, 0, 0, 0);
    cyc2(0, 0, 0, 0);
    chk("stv_drain_sel", b2.cdb_sel_o, 0);

    // Mispredict flushes the multiply reservations
    cyc2(0, 1, 0, 0);
    chk("mp_t0_mult_gnt", b2.mult_gnt_o, 1);
    cyc2(1, 1, 1, 0);
    chk("mp_t1_gnt", {b2.alu_gnt_o, b2.mult_gnt_o}, 2'b00);
    chk("mp_t1_inflight", b2.mult_inflight_o, 1);
    cyc2(0, 0, 0, 0);
    chk("mp_t2_sel", b2.cdb_sel_o, 0);
    chk("mp_t2_inflight", b2.mult_inflight_o, 0);
    cyc2(0, 0, 0, 0);
    chk("mp_t3_sel", b2.cdb_sel_o, 0);

    // MULT_LAT_P=4: normal latency
    cyc4(0, 0, 0, 0);
    chk("l4_idle_sel", b4.cdb_sel_o, 0);
    cyc4(0, 1, 0, 0);
    chk("l4_g0_mult_gnt", b4.mult_gnt_o, 1);
    cyc4(0, 0, 0, 0);
    cyc4(0, 0, 0, 0);
    cyc4(0, 0, 0, 0);
    chk("l4_g3_sel", b4.cdb_sel_o, 0);
    chk("l4_g3_inflight", b4.mult_inflight_o, 1);
    cyc4(0, 0, 0, 0);
    chk("l4_g4_sel", b4.cdb_sel_o, 2);
    chk("l4_g4_inflight", b4.mult_inflight_o, 0);
    cyc4(0, 0, 0, 0);

    // MULT_LAT_P=4: reset with three multiplies in flight
    cyc4(0, 1, 0, 0);
    chk("l4_f0_mult_gnt", b4.mult_gnt_o, 1);
    cyc4(0, 1, 0, 0);
    chk("l4_f1_inflight", b4.mult_inflight_o, 1);
    cyc4(0, 1, 0, 0);
    chk("l4_f2_inflight", b4.mult_inflight_o, 2);
    cyc4(0, 1, 0, 1);
    chk("l4_f3_inflight", b4.mult_inflight_o, 3);
    chk("l4_f3_mult_gnt", b4.mult_gnt_o, 0);
    for (int i = 4; i < 8; i++) begin
      cyc4(0, 0, 0, 0);
      chk($sformatf("l4_f%0d_sel", i), b4.cdb_sel_o, 0);
      chk($sformatf("l4_f%0d_inflight", i), b4.mult_inflight_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
